semaforo_peatonal: RTL

Pedestrian-crossing controller placed directly downstream of the intersection light sequencer. It decodes the 8-bit vehicle light pattern and debounces a raw push-button. It grants a full walk interval only from the start of the cross-traffic-green phase, flashes don't-walk during the following yellow phase, and flags any illegal light pattern. It shares the sequencer's clock and reset.

---
 rtl/semaforo_pkg.sv | 38 +++
 rtl/semaforo_peatonal_antirrebote.sv | 46 ++++
 rtl/semaforo_peatonal.sv | 131 +++++++++++++
 3 files changed

// File: rtl/semaforo_pkg.sv
// Shared definitions for the intersection sequencer and the pedestrian controller:
// light patterns, lamp bit positions and the crossing FSM states.
package semaforo_pkg;

  localparam int H1_ROJO     = 7;
  localparam int H1_AMARILLO = 6;
  localparam int H1_VERDE    = 5;
  localparam int H2_ROJO     = 2;
  localparam int H2_AMARILLO = 1;
  localparam int H2_VERDE    = 0;

  localparam logic [7:0] LUCES_A   = (8'd1 << H1_ROJO)     | (8'd1 << H2_VERDE);
  localparam logic [7:0] LUCES_B   = (8'd1 << H1_ROJO)     | (8'd1 << H2_AMARILLO);
  localparam logic [7:0] LUCES_C   = (8'd1 << H1_VERDE)    | (8'd1 << H2_ROJO);
  localparam logic [7:0] LUCES_D   = (8'd1 << H1_AMARILLO) | (8'd1 << H2_ROJO);
  localparam logic [7:0] LUCES_OFF = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WALK  = 2'd2,
    FLASH = 2'd3
  } estado_t;

  function automatic logic luces_legal(input logic [7:0] l);
    return (l == LUCES_A) || (l == LUCES_B) || (l == LUCES_C) ||
           (l == LUCES_D) || (l == LUCES_OFF);
  endfunction

  // Where the FSM lands when it leaves its current phase: a pending request
  // caught exactly at C entry is served at once, otherwise it waits.
  function automatic estado_t salida(input logic pendiente, input logic entrada_c);
    if (pendiente && entrada_c) return WALK;
    else if (pendiente)         return WAIT;
    else                        return IDLE;
  endfunction

endpackage

// File: rtl/semaforo_peatonal_antirrebote.sv
// Push-button conditioner: 2-flop synchroniser, DEBOUNCE-cycle stability filter
// and a one-cycle pulse that coincides with the debounced level going high.
module antirrebote #(
  parameter int DEBOUNCE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic boton,
  output logic subida
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic          nivel;
  logic [CW-1:0] cnt;
  logic          cambia;

  // Pulse is issued in the same cycle the level flips so the request lands on that edge.
  assign cambia = (sync2 != nivel) && (cnt == CNT_LAST);
  assign subida = cambia && sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      nivel <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= boton;
      sync2 <= sync1;
      if (sync2 == nivel) begin
        cnt <= '0;
      end else if (cambia) begin
        cnt   <= '0;
        nivel <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/semaforo_peatonal.sv
// Pedestrian-crossing controller: decodes the sequencer's light pattern, grants a
// walk interval from the start of cross-green, flashes don't-walk during yellow.
module semaforo_peatonal
  import semaforo_pkg::*;
#(
  parameter int DEBOUNCE   = 4,
  parameter int FLASH_HALF = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] luces,
  input  logic       boton,
  output logic       walk,
  output logic       dont_walk,
  output logic       wait_lamp,
  output logic       fault,
  output logic [7:0] served
);

  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  estado_t       state;
  estado_t       state_next;
  logic          req;
  logic          req_next;
  logic          req_eff;
  logic [7:0]    luces_prev;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_next;
  logic          fphase;
  logic          fphase_next;
  logic [7:0]    served_next;
  logic          entra_walk;
  logic          subida;
  logic          ilegal;
  logic          entrada_c;
  logic          walk_d;
  logic          dont_walk_d;
  logic          wait_lamp_d;

  antirrebote #(
    .DEBOUNCE (DEBOUNCE)
  ) u_antirrebote (
    .clock  (clock),
    .reset  (reset),
    .boton  (boton),
    .subida (subida)
  );

  assign ilegal    = !luces_legal(luces);
  assign entrada_c = (luces == LUCES_C) && (luces_prev != LUCES_C);
  assign req_eff   = req | subida;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req        <= 1'b0;
      luces_prev <= LUCES_OFF;
      fcnt       <= '0;
      fphase     <= 1'b1;
      served     <= 8'd0;
      walk       <= 1'b0;
      dont_walk  <= 1'b1;
      wait_lamp  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_next;
      req        <= req_next;
      luces_prev <= luces;
      fcnt       <= fcnt_next;
      fphase     <= fphase_next;
      served     <= served_next;
      walk       <= walk_d;
      dont_walk  <= dont_walk_d;
      wait_lamp  <= wait_lamp_d;
      fault      <= ilegal;
    end
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_next  = state;
    req_next    = req_eff;
    entra_walk  = 1'b0;
    served_next = served;
    fcnt_next   = fcnt;
    fphase_next = fphase;

    if (ilegal) begin
      state_next = req_eff ? WAIT : IDLE;
    end else begin
      unique case (state)
        IDLE:  state_next = salida(req_eff, entrada_c);
        WAIT:  if (entrada_c) state_next = WALK;
        WALK: begin
          if (luces == LUCES_D)      state_next = FLASH;
          else if (luces != LUCES_C) state_next = salida(req_eff, entrada_c);
        end
        FLASH: if (luces != LUCES_D) state_next = salida(req_eff, entrada_c);
        default: state_next = IDLE;
      endcase
    end

    entra_walk = (state_next == WALK) && (state != WALK);
    if (entra_walk) begin
      req_next    = 1'b0;
      served_next = served + 8'd1;
    end

    // Flash phase starts lit on the first FLASH cycle and flips every FLASH_HALF cycles.
    if (state_next == FLASH) begin
      if (state != FLASH) begin
        fcnt_next   = '0;
        fphase_next = 1'b1;
      end else if (fcnt == FLASH_LAST) begin
        fcnt_next   = '0;
        fphase_next = ~fphase;
      end else begin
        fcnt_next = fcnt + FW'(1);
      end
    end
  end

  always_comb begin
    walk_d      = (state_next == WALK);
    dont_walk_d = (state_next == FLASH) ? fphase_next : (state_next != WALK);
    wait_lamp_d = req_next || (state_next == WAIT);
  end

endmodule
